// File: rtl/simmem_resp_release_scheduler.sv
// Release scheduler for the response banks: per-slot delay countdown, per-ID
// ordering via slot rank, and a round-robin pick among matured IDs with a grant lock.

module simmem_resp_slot #(
  parameter int IDWidth    = 4,
  parameter int DelayWidth = 6,
  parameter int RankW      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc,
  input  logic [IDWidth-1:0]    new_id,
  input  logic [DelayWidth-1:0] new_delay,
  input  logic [RankW-1:0]      new_rank,
  input  logic                  rel,
  input  logic [IDWidth-1:0]    rel_id,
  output logic                  valid,
  output logic [IDWidth-1:0]    id,
  output logic                  eligible
);
  logic [DelayWidth-1:0] counter;
  logic [RankW-1:0]      rank;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      id      <= '0;
      counter <= '0;
      rank    <= '0;
    end else if (alloc) begin
      valid   <= 1'b1;
      id      <= new_id;
      counter <= new_delay;
      rank    <= new_rank;
    end else if (valid) begin
      // Rank 0 of the released ID is the granted slot; younger siblings move up.
      if (rel && id == rel_id) begin
        if (rank == '0) valid <= 1'b0;
        else            rank  <= rank - RankW'(1);
      end
      if (counter != '0) counter <= counter - DelayWidth'(1);
    end
  end

  assign eligible = valid && rank == '0 && counter == '0;
endmodule

module simmem_resp_release_scheduler #(
  parameter int NumSlots   = 32,
  parameter int IDWidth    = 4,
  parameter int DelayWidth = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [IDWidth-1:0]        in_id_i,
  input  logic [DelayWidth-1:0]     in_delay_i,
  output logic                      release_valid_o,
  input  logic                      release_ready_i,
  output logic [IDWidth-1:0]        release_id_o,
  output logic [$clog2(NumSlots):0] occupancy_o
);
  localparam int NumIds = 2 ** IDWidth;
  localparam int RankW  = $clog2(NumSlots);
  localparam int CntW   = RankW + 1;

  logic [NumSlots-1:0]              slot_valid, slot_elig, slot_alloc;
  logic [NumSlots-1:0][IDWidth-1:0] slot_id;
  logic [NumIds-1:0]                id_elig;
  logic [NumIds-1:0][CntW-1:0]      count_q;
  logic [IDWidth-1:0]               rr_q, lock_id_q, pick, grant, idx;
  logic                             lock_q, found, en, hs;
  logic [RankW-1:0]                 alloc_idx, new_rank;
  logic [CntW-1:0]                  occ_q;

  assign in_ready_o = ~&slot_valid;
  assign en         = in_valid_i && in_ready_o;
  assign hs         = release_valid_o && release_ready_i;

  // Lowest-index free slot, chosen from pre-edge state only.
  always_comb begin
    alloc_idx = '0;
    for (int s = NumSlots - 1; s >= 0; s--)
      if (!slot_valid[s]) alloc_idx = RankW'(s);
  end

  // A same-ID release this cycle shifts the newcomer's rank down by one.
  assign new_rank = RankW'(count_q[in_id_i] - CntW'(hs && grant == in_id_i));

  for (genvar g = 0; g < NumSlots; g++) begin : g_slot
    assign slot_alloc[g] = en && alloc_idx == RankW'(g);
    simmem_resp_slot #(
      .IDWidth   (IDWidth),
      .DelayWidth(DelayWidth),
      .RankW     (RankW)
    ) u_slot (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .alloc    (slot_alloc[g]),
      .new_id   (in_id_i),
      .new_delay(in_delay_i),
      .new_rank (new_rank),
      .rel      (hs),
      .rel_id   (grant),
      .valid    (slot_valid[g]),
      .id       (slot_id[g]),
      .eligible (slot_elig[g])
    );
  end

  always_comb begin
    id_elig = '0;
    for (int s = 0; s < NumSlots; s++)
      if (slot_elig[s]) id_elig[slot_id[s]] = 1'b1;
  end

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int j = 0; j < NumIds; j++) begin
      idx = rr_q + IDWidth'(j);
      if (!found && id_elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign grant           = lock_q ? lock_id_q : pick;
  assign release_valid_o = lock_q || found;
  assign release_id_o    = release_valid_o ? grant : '0;
  assign occupancy_o     = occ_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q   <= '0;
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      occ_q     <= '0;
    end else begin
      for (int k = 0; k < NumIds; k++)
        count_q[k] <= count_q[k] + CntW'(en && in_id_i == IDWidth'(k))
                                 - CntW'(hs && grant == IDWidth'(k));
      // A stalled grant is frozen so the bank sees a stable ID until it accepts.
      if (hs) begin
        rr_q   <= grant + IDWidth'(1);
        lock_q <= 1'b0;
      end else if (release_valid_o) begin
        lock_q    <= 1'b1;
        lock_id_q <= grant;
      end
      occ_q <= occ_q + CntW'(en) - CntW'(hs);
    end
  end
endmodule

// File: tb/tb_simmem_resp_release_scheduler.sv
// Randomized scoreboard bench: a per-ID queue model predicts every cycle's outputs.

module tb_simmem_resp_release_scheduler;
  localparam int NumSlots = 32;
  localparam int NumIds   = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni, in_valid_i, in_ready_o, release_valid_o, release_ready_i;
  logic [3:0] in_id_i, release_id_o;
  logic [5:0] in_delay_i;
  logic [5:0] occupancy_o;

  simmem_resp_release_scheduler dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_id_i        (in_id_i),
    .in_delay_i     (in_delay_i),
    .release_valid_o(release_valid_o),
    .release_ready_i(release_ready_i),
    .release_id_o   (release_id_o),
    .occupancy_o    (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit rv;
    int rid;
    bit rdy;
    int occ;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Model: per-ID FIFO of the cycle in which each response matures.
  int   mq[NumIds][$];
  int   cyc = 0;
  int   rr = 0;
  bit   lock = 0;
  int   lock_id = 0;

  function automatic int total();
    int t = 0;
    for (int k = 0; k < NumIds; k++) t += mq[k].size();
    return t;
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    e.rv = 0; e.rid = 0; e.cyc = cyc;
    e.occ = total();
    e.rdy = (e.occ < NumSlots);
    if (lock) begin
      e.rv = 1; e.rid = lock_id;
    end else begin
      for (int j = 0; j < NumIds; j++) begin
        int k = (rr + j) % NumIds;
        if (!e.rv && mq[k].size() > 0 && mq[k][0] <= cyc) begin
          e.rv = 1; e.rid = k;
        end
      end
    end
    return e;
  endfunction

  function automatic void model_step(bit v, int id, int d, bit rdy, bit rst, exp_t e);
    if (rst) begin
      for (int k = 0; k < NumIds; k++) mq[k].delete();
      rr = 0; lock = 0; lock_id = 0;
    end else begin
      if (e.rv && rdy) begin
        void'(mq[e.rid].pop_front());
        rr = (e.rid + 1) % NumIds;
        lock = 0;
      end else if (e.rv) begin
        lock = 1; lock_id = e.rid;
      end
      if (v && e.rdy) mq[id].push_back(cyc + 1 + d);
    end
    cyc++;
  endfunction

  // Called at posedge+1; drives one cycle and books its expected outputs.
  task automatic step(input bit v, input int id, input int d, input bit rdy, input bit rst);
    exp_t e;
    in_valid_i = v; in_id_i = 4'(id); in_delay_i = 6'(d);
    release_ready_i = rdy; rst_ni = !rst;
    e = model_expect();
    exp_q.push_back(e);
    @(posedge clk_i);
    model_step(v, id, d, rdy, rst, e);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, rdy, 0);
  endtask

  task automatic chk(input string name, input int c, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, got, want);
    end
  endtask

  initial begin : monitor
    exp_t m;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        m = exp_q.pop_front();
        chk("release_valid", m.cyc, int'(release_valid_o), int'(m.rv));
        chk("release_id", m.cyc, int'(release_id_o), m.rid);
        chk("in_ready", m.cyc, int'(in_ready_o), int'(m.rdy));
        chk("occupancy", m.cyc, int'(occupancy_o), m.occ);
      end
    end
  end

  initial begin : driver
    rst_ni = 0; in_valid_i = 0; in_id_i = 0; in_delay_i = 0; release_ready_i = 0;
    @(posedge clk_i);
    model_step(0, 0, 0, 0, 1, exp_t'{0, 0, 0, 0, 0});
    #1;

    // Single response, delay 5.
    step(1, 3, 5, 1, 0);
    idle(8, 1);

    // Same ID, younger matures first but must wait for the older one.
    step(1, 2, 10, 1, 0);
    step(1, 2, 0, 1, 0);
    idle(14, 1);

    // Three IDs maturing together from rr=0, then probe the pointer at 10.
    step(0, 0, 0, 1, 1);
    step(1, 1, 4, 1, 0);
    step(1, 4, 3, 1, 0);
    step(1, 9, 2, 1, 0);
    idle(8, 1);
    step(1, 11, 3, 1, 0);
    step(1, 10, 2, 1, 0);
    idle(8, 1);

    // Grant lock on ID 5 while ID 0 matures.
    step(0, 0, 0, 0, 1);
    step(1, 5, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    idle(4, 0);
    idle(4, 1);

    // Fill all slots, then release plus enqueue attempt while full.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < NumSlots; i++) step(1, $urandom_range(0, 15), 0, 0, 0);
    step(1, 7, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    idle(40, 1);

    // Reset with entries pending.
    step(1, 1, 20, 0, 0);
    step(1, 2, 20, 0, 0);
    step(1, 3, 20, 0, 0);
    step(0, 0, 0, 1, 1);
    idle(70, 1);

    // Random traffic with a narrow-ID phase and sparse resets.
    for (int i = 0; i < 4000; i++) begin
      bit narrow = (i % 1000) < 500;
      int id     = narrow ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      int d      = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 63));
      bit v      = $urandom_range(0, 99) < 60;
      bit rdy    = ((i / 400) % 2 == 0) ? ($urandom_range(0, 99) < 80)
                                        : ($urandom_range(0, 99) < 25);
      bit rst    = $urandom_range(0, 999) == 0;
      step(v, id, d, rdy, rst);
    end
    idle(80, 1);

    @(negedge clk_i);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/simmem_resp_release_scheduler.md
Name: simmem_resp_release_scheduler

Overview:
- Timing controller for the write-response and read-data banks.
- Holds one slot per outstanding response. Each slot carries an AXI ID and a programmable delay countdown.
- Decides which ID the bank may release each cycle.
- Keeps per-ID AXI ordering and arbitrates round-robin between IDs whose oldest response has matured.
- Sits between the address-channel request path, which enqueues, and the bank output stage, which dequeues.

Parameters:
- NumSlots, 32, maximum outstanding responses tracked (equals WriteRespBankTotalCapacity).
- IDWidth, 4, AXI ID width; NumIds = 2**IDWidth.
- DelayWidth, 6, width of the per-response delay in cycles.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- in_valid_i  in  1  new response to schedule
- in_ready_o  out  1  free slot available
- in_id_i  in  IDWidth  AXI ID of new response
- in_delay_i  in  DelayWidth  cycles before the response may be released
- release_valid_o  out  1  a response is releasable
- release_ready_i  in  1  bank accepts the release
- release_id_o  out  IDWidth  ID to release from the bank
- occupancy_o  out  $clog2(NumSlots)+1  number of valid slots

Behaviour:

Reset and handshakes:
- Reset is synchronous, active-low, one clock; clk_i is the only clock.
- On reset: all slots invalid, all per-ID counts 0, round-robin pointer 0, grant lock cleared.
- Reset outputs: in_ready_o=1, release_valid_o=0, release_id_o=0, occupancy_o=0.
- Reset mid-operation discards every pending entry; nothing is released afterwards.
- Enqueue handshake: in_valid_i && in_ready_o at a rising edge.
- Release handshake: release_valid_o && release_ready_i at a rising edge.

Slot state and enqueue:
- Per-slot state: valid, id, counter (DelayWidth), rank (the slot's position among same-ID entries, 0 = oldest).
- Enqueue allocates the lowest-index free slot: counter <= in_delay_i, rank <= count[in_id_i], count[in_id_i] += 1.
- in_ready_o = any slot invalid. It is purely registered-state derived and has no path from release_ready_i.
- When full, a release in the same cycle does not raise in_ready_o until the next cycle.

Counters and eligibility:
- Each valid slot's counter decrements by 1 every cycle and saturates at 0.
- A slot is eligible when valid && rank==0 && counter==0. An ID is eligible when it owns an eligible slot; at most one slot per ID can be eligible.
- Latency: response enqueued at edge t with delay d has counter d in cycle t+1. It becomes eligible in cycle t+1+d (d=0 gives cycle t+1), subject to rank and arbitration.

Arbitration and grant lock:
- Round-robin among eligible IDs: pick the first eligible ID scanning upward from the pointer rr_q, wrapping modulo NumIds.
- release_valid_o = any eligible ID; release_id_o = the chosen ID.
- Grant lock: if release_valid_o=1 and release_ready_i=0, the chosen ID is registered and held. release_id_o must not change until the handshake, even if a higher-priority ID becomes eligible meanwhile.
- Eligibility never deasserts without a handshake.
- On handshake for ID k:
  - the rank-0 slot of k is invalidated;
  - every other valid slot with id==k decrements its rank;
  - count[k] -= 1;
  - rr_q <= (k+1) mod NumIds;
  - the lock clears.

Occupancy and simultaneous events:
- occupancy_o = number of valid slots; +1 on enqueue, -1 on release, unchanged when both happen.
- Simultaneous enqueue and release of the same ID: the new slot's rank = count[k]-1, and count[k] is unchanged.
- Simultaneous enqueue into the slot freed this cycle cannot happen, because the allocation choice uses pre-edge state.
- Out-of-order maturity within one ID: a younger entry whose counter reaches 0 waits at counter 0 until it reaches rank 0, then is eligible immediately.
- release_id_o is 0 whenever release_valid_o=0.

Test Plan:
1. Reset, then enqueue id=3, delay=5 at edge t, release_ready_i=1 → release_valid_o=1 with release_id_o=3 in cycle t+6 only; occupancy_o goes 1 → 0 after the release.
2. Enqueue id=2 with delay=10, then id=2 with delay=0 → the second entry is released exactly 1 cycle after the first, never before it.
3. IDs 1, 4, 9 all eligible in the same cycle with rr_q=0, ready held high → release order 1, 4, 9 on consecutive cycles; after that rr_q=10.
4. ID 5 eligible with ready=0 for 4 cycles while ID 0 becomes eligible → release_id_o stays 5 throughout; when ready=1, 5 is released and 0 follows in the next cycle.
5. Fill 32 slots → in_ready_o=0. A release plus an enqueue attempt in the same cycle → the enqueue is not accepted; in_ready_o=1 in the next cycle.
6. Enqueue 3 entries, then assert rst_ni=0 for 1 cycle → all outputs return to reset values; no release occurs over the following 70 cycles.
